// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: latches the memory-stage result, writes the register file,
// feeds the ID bypass, counts retired instructions and halts the core on ebreak.
module wb_commit_stage #(
    parameter int PC_WD      = 32,
    parameter int INST_WD    = 32,
    parameter int RF_ADDR_WD = 5,
    parameter int RF_DATA_WD = 64,
    parameter int CNT_WD     = 64
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  ms_to_ws_valid,
    input  logic [PC_WD-1:0]      ms_pc,
    input  logic [INST_WD-1:0]    ms_inst,
    input  logic                  ms_rf_wen,
    input  logic [RF_ADDR_WD-1:0] ms_rf_waddr,
    input  logic [RF_DATA_WD-1:0] ms_rf_wdata,
    input  logic                  ms_exp,
    input  logic                  ms_mret,
    input  logic                  ms_ebreak,
    input  logic                  ws_hold,
    output logic                  ws_allowin,
    output logic                  rf_we,
    output logic [RF_ADDR_WD-1:0] rf_waddr,
    output logic [RF_DATA_WD-1:0] rf_wdata,
    output logic                  ws_fwd_valid,
    output logic [RF_ADDR_WD-1:0] ws_fwd_addr,
    output logic [RF_DATA_WD-1:0] ws_fwd_data,
    output logic                  ws_valid,
    output logic [PC_WD-1:0]      debug_wb_pc,
    output logic [INST_WD-1:0]    debug_wb_inst,
    output logic                  debug_wb_exp,
    output logic                  debug_wb_mret,
    output logic                  stop,
    output logic [CNT_WD-1:0]     retire_cnt
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t state, state_nxt;

    logic                  ws_valid_p0;
    logic [PC_WD-1:0]      pc_p0;
    logic [INST_WD-1:0]    inst_p0;
    logic                  wen_p0;
    logic [RF_ADDR_WD-1:0] waddr_p0;
    logic [RF_DATA_WD-1:0] wdata_p0;
    logic                  exp_p0;
    logic                  mret_p0;
    logic                  ebreak_p0;
    logic [CNT_WD-1:0]     cnt_p0;

    logic ready_go;
    logic commit;
    logic halt_req;
    logic writes_rd_p0;

    // An excepting instruction or a write to x0 never updates architectural state.
    function automatic logic writes_rd(input logic wen, input logic exp,
                                       input logic [RF_ADDR_WD-1:0] addr);
        return wen && !exp && (addr != '0);
    endfunction

    assign ready_go     = !ws_hold;
    assign commit       = ws_valid_p0 && ready_go && (state == RUN);
    assign halt_req     = commit && ebreak_p0 && !exp_p0;
    assign writes_rd_p0 = writes_rd(wen_p0, exp_p0, waddr_p0);

    // ---- stage boundary: memory -> writeback pipeline register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ws_valid_p0 <= 1'b0;
            pc_p0       <= '0;
            inst_p0     <= '0;
            wen_p0      <= 1'b0;
            waddr_p0    <= '0;
            wdata_p0    <= '0;
            exp_p0      <= 1'b0;
            mret_p0     <= 1'b0;
            ebreak_p0   <= 1'b0;
        end else if (ws_allowin) begin
            ws_valid_p0 <= ms_to_ws_valid;
            if (ms_to_ws_valid) begin
                pc_p0     <= ms_pc;
                inst_p0   <= ms_inst;
                wen_p0    <= ms_rf_wen;
                waddr_p0  <= ms_rf_waddr;
                wdata_p0  <= ms_rf_wdata;
                exp_p0    <= ms_exp;
                mret_p0   <= ms_mret;
                ebreak_p0 <= ms_ebreak;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_p0 <= '0;
        end else if (commit) begin
            cnt_p0 <= cnt_p0 + CNT_WD'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (halt_req) state_nxt = HALT;
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    // allowin uses the current state, so an instruction arriving alongside the
    // halting ebreak is still accepted; it then sits in the stage uncommitted.
    always_comb begin
        ws_allowin = !resetn || ((!ws_valid_p0 || ready_go) && (state == RUN));
        stop       = (state == HALT);
    end

    // ---- stage boundary: commit outputs
    assign rf_we         = commit && writes_rd_p0;
    assign rf_waddr      = waddr_p0;
    assign rf_wdata      = wdata_p0;

    assign ws_fwd_valid  = ws_valid_p0 && writes_rd_p0;
    assign ws_fwd_addr   = waddr_p0;
    assign ws_fwd_data   = wdata_p0;

    assign ws_valid      = commit;
    assign debug_wb_pc   = pc_p0;
    assign debug_wb_inst = inst_p0;
    assign debug_wb_exp  = exp_p0;
    assign debug_wb_mret = mret_p0;
    assign retire_cnt    = cnt_p0;

endmodule

// File: doc/wb_commit_stage.md
Name: wb_commit_stage

Overview:
- Final (writeback) stage of the 5-stage core; accepts one instruction per cycle from the memory stage over a valid/allowin handshake.
- Performs the register-file write, drives the ID-stage bypass and retire counter, and detects `ebreak` halt.
- Produces the commit-side debug signals (`ws_valid`, `debug_wb_pc`, `debug_wb_inst`, rf write triple, `stop`) consumed by the DPI-C trace/difftest block.

Parameters:
- PC_WD, 32, PC width
- INST_WD, 32, instruction width
- RF_ADDR_WD, 5, register index width
- RF_DATA_WD, 64, register data width
- CNT_WD, 64, retire counter width

Ports:
- clk  in  1  core clock; all state on posedge
- resetn  in  1  synchronous, active-low reset
- ms_to_ws_valid  in  1  memory stage presents an instruction
- ms_pc  in  PC_WD  PC of presented instruction
- ms_inst  in  INST_WD  instruction word
- ms_rf_wen  in  1  instruction writes rd
- ms_rf_waddr  in  RF_ADDR_WD  rd index
- ms_rf_wdata  in  RF_DATA_WD  rd data
- ms_exp  in  1  instruction raised an exception
- ms_mret  in  1  instruction is mret
- ms_ebreak  in  1  instruction is ebreak
- ws_hold  in  1  external commit hold (debugger/difftest backpressure)
- ws_allowin  out  1  stage can accept this cycle
- rf_we  out  1  register-file write enable
- rf_waddr  out  RF_ADDR_WD  write index
- rf_wdata  out  RF_DATA_WD  write data
- ws_fwd_valid  out  1  bypass entry valid (to ID)
- ws_fwd_addr  out  RF_ADDR_WD  bypass rd
- ws_fwd_data  out  RF_DATA_WD  bypass data
- ws_valid  out  1  instruction committing this cycle
- debug_wb_pc  out  PC_WD  committing PC
- debug_wb_inst  out  INST_WD  committing instruction
- debug_wb_exp  out  1  committing instruction had exception
- debug_wb_mret  out  1  committing instruction is mret
- stop  out  1  halt reached
- retire_cnt  out  CNT_WD  number of committed instructions

Behaviour:
- **Pipeline register.**
  - `ws_valid_r`, pc, inst, rf_* and the exp/mret/ebreak flags are latched when `ms_to_ws_valid && ws_allowin`.
  - `ws_ready_go = !ws_hold`.
  - `ws_allowin = (!ws_valid_r || ws_ready_go) && state==RUN`.
  - When `ws_allowin=1` and `ms_to_ws_valid=0`, `ws_valid_r` clears.
- **Commit.**
  - Commit fires when `ws_valid_r && ws_ready_go`.
  - `ws_valid` equals this commit condition, so it is 0 during hold.
  - Latency: an instruction handed over in cycle N commits in cycle N+1 if not held.
- **RF write.**
  - `rf_we = commit && wen && !exp && waddr!=0`.
  - `rf_waddr`/`rf_wdata` always reflect the latched values.
  - Writes to x0 never assert `rf_we`.
- **Bypass.**
  - `ws_fwd_valid = ws_valid_r && wen && !exp && waddr!=0`.
  - It is independent of hold, so the bypass stays valid while the stage is held.
- **Debug outputs.** `debug_wb_*` are driven from the latched registers. When `ws_valid_r=0` they hold their last value.
- **Retire counter.**
  - `retire_cnt` increments by 1 on each commit, including exp, mret and ebreak commits.
  - It wraps from all-ones to 0.
- **State machine (RUN → HALT).**
  - RUN: normal operation.
  - A committing instruction with ebreak=1 moves the FSM to HALT in the next cycle.
  - HALT: `ws_allowin=0`, `stop=1`, no further commits, and the counter is frozen.
  - HALT exits only on reset.
  - `stop` is registered and rises in the cycle after the ebreak commit.
- **Simultaneous events.**
  - ebreak commit with `ms_to_ws_valid=1` in the same cycle: the incoming instruction is accepted, because `allowin` is computed from the current state. It then never commits.
  - ebreak with exp=1: the exception takes priority; no halt, the FSM stays in RUN.
- **Reset** (`resetn=0` at posedge, including mid-hold or in HALT):
  - `ws_valid_r=0`, state=RUN, `stop=0`, `retire_cnt=0`.
  - pc/inst/rf data/flags=0, so all outputs are 0.
  - In the reset cycle `ws_allowin` reads 1.

Test Plan:
- Back-to-back: 3 instructions (x5←0x11, x6←0x22, x7←0x33) on consecutive cycles → `rf_we` high for 3 consecutive cycles with matching addr/data; `retire_cnt`=3; `debug_wb_pc` matches each.
- x0 and exception: write x0←0xFF, then x8←0x44 with exp=1 → `rf_we` stays 0 for both; `ws_valid` pulses twice; `retire_cnt`=2; `ws_fwd_valid`=0 for both.
- Hold: `ws_hold`=1 for 3 cycles with an instruction latched → `ws_valid`=0, `ws_allowin`=0, `ws_fwd_valid`=1, counter frozen; the instruction commits on the first cycle after hold drops.
- Halt: ebreak at pc 0x80000010 followed by a valid instruction → commit of 0x80000010, then `stop`=1 and `ws_allowin`=0; the follower never asserts `ws_valid`; the counter stops.
- Reset mid-halt: assert `resetn`=0 in HALT for one cycle → `stop`=0, `retire_cnt`=0, `ws_valid`=0; the next instruction commits normally.
- ebreak with exp=1 → no `stop`; the following instruction commits.
